// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: MEM-stage FSM state encodings shared by the MEM stage files
package mem_stage_ctrl_pkg;
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_ERR  = 2'd2
    } ms_state_e;
endpackage

// File: rtl/mem_stage_ctrl_dmem_wait_timer.sv
// mem_stage_ctrl_dmem_wait_timer: dmem wait-state counter, expired once the count reaches TIMEOUT_CYC
module mem_stage_ctrl_dmem_wait_timer #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    always_comb wcnt_d = clr ? '0 : inc ? wcnt_q + 1'b1 : wcnt_q;
    always_ff @(negedge clk) wcnt_q <= rst ? '0 : wcnt_d;
    assign expired = wcnt_q == CNT_W'(TIMEOUT_CYC);
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage branch resolve, dmem req/ack with timeout and MEM/WB register; MEM_OVF_SUPPRESS_EN blocks overflowed accesses
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] MEM_ALUout,
    input  logic [31:0] MEM_busB,
    input  logic [31:0] MEM_Btarg,
    input  logic [31:0] MEM_Jtarg,
    input  logic [4:0]  MEM_Rw,
    input  logic        MEM_Zero,
    input  logic        MEM_Overflow,
    input  logic        MEM_RegWr,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemWr,
    input  logic        MEM_Branch,
    input  logic        MEM_Jump,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        MEM_PCSrc,
    output logic [31:0] MEM_NextPC,
    output logic        MEM_Stall,
    output logic [31:0] WB_Dout,
    output logic [31:0] WB_ALUout,
    output logic [4:0]  WB_Rw,
    output logic        WB_RegWr,
    output logic        WB_MemtoReg,
    output logic        MemErr
);
    ms_state_e   state_q, state_d;
    logic        sup, acc, req, stall, bub, clr, inc, expired;
    logic        mem_err_q, mem_err_d;
    logic [31:0] wb_dout_q, wb_dout_d, wb_alu_q, wb_alu_d;
    logic [4:0]  wb_rw_q, wb_rw_d;
    logic        wb_regwr_q, wb_regwr_d, wb_mtr_q, wb_mtr_d;
`ifdef MEM_OVF_SUPPRESS_EN
    assign sup = MEM_Overflow;
`else
    logic unused_ovf;
    assign unused_ovf = MEM_Overflow;
    assign sup = 1'b0;
`endif
    always_comb begin
        acc        = (MEM_MemWr | MEM_MemtoReg) & ~sup;
        req        = ~Rst & acc & (state_q != MS_ERR);
        stall      = req & ~dmem_ack;
        state_d    = state_q == MS_IDLE ? (stall ? MS_WAIT : MS_IDLE) :
                     state_q == MS_WAIT ? (dmem_ack ? MS_IDLE : expired ? MS_ERR : MS_WAIT) : MS_IDLE;
        clr        = (state_q == MS_ERR) | (state_q == MS_WAIT & dmem_ack);
        inc        = (state_q == MS_IDLE & stall) | (state_q == MS_WAIT & ~dmem_ack & ~expired);
        mem_err_d  = mem_err_q | (state_q == MS_ERR);
        bub        = (state_q == MS_ERR) | stall;
        wb_alu_d   = bub ? '0 : MEM_ALUout;
        wb_rw_d    = bub ? '0 : MEM_Rw;
        wb_mtr_d   = ~bub & MEM_MemtoReg;
        wb_regwr_d = ~bub & MEM_RegWr & ~sup;
        wb_dout_d  = (~bub & acc & MEM_MemtoReg) ? dmem_rdata : '0;
    end
    // Pipeline registers in this design update on the falling edge.
    always_ff @(negedge Clk) begin
        if (Rst) begin
            state_q    <= MS_IDLE;
            mem_err_q  <= 1'b0;
            wb_dout_q  <= '0;
            wb_alu_q   <= '0;
            wb_rw_q    <= '0;
            wb_regwr_q <= 1'b0;
            wb_mtr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_err_q  <= mem_err_d;
            wb_dout_q  <= wb_dout_d;
            wb_alu_q   <= wb_alu_d;
            wb_rw_q    <= wb_rw_d;
            wb_regwr_q <= wb_regwr_d;
            wb_mtr_q   <= wb_mtr_d;
        end
    end
    mem_stage_ctrl_dmem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_timer (
        .clk(Clk), .rst(Rst), .clr(clr), .inc(inc), .expired(expired)
    );
    assign dmem_req    = req;
    assign dmem_we     = MEM_MemWr & req;
    assign dmem_addr   = MEM_ALUout;
    assign dmem_wdata  = MEM_busB;
    assign MEM_PCSrc   = (MEM_Branch & MEM_Zero) | MEM_Jump;
    assign MEM_NextPC  = MEM_Jump ? MEM_Jtarg : MEM_Btarg;
    assign MEM_Stall   = stall;
    assign WB_Dout     = wb_dout_q;
    assign WB_ALUout   = wb_alu_q;
    assign WB_Rw       = wb_rw_q;
    assign WB_RegWr    = wb_regwr_q;
    assign WB_MemtoReg = wb_mtr_q;
    assign MemErr      = mem_err_q;
endmodule
